// File: rtl/tile_vram_pkg.sv
// Shared types and defaults for the playfield tile-map VRAM fetcher.
package tile_vram_pkg;

    localparam int DEF_COLS_LOG2 = 5;
    localparam int DEF_ROWS_LOG2 = 5;
    localparam logic [2:0] DEF_FETCH_PHASE = 3'b001;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_DATA = 2'd1,
        C_WAIT = 2'd2
    } cpu_state_t;

    // The fetch runs one cell ahead of the beam; the column wraps mod 32.
    function automatic logic [DEF_COLS_LOG2-1:0] next_col(input logic [DEF_COLS_LOG2-1:0] col);
        return col + 1'b1;
    endfunction

endpackage

// File: rtl/vram_sp.sv
// Single-port synchronous RAM with registered read data; the only memory in the fetcher.
module vram_sp #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-old-data on a write cycle; callers never rely on q after a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/tile_vram_fetch.sv
// Tile-map VRAM with display-priority arbitration against a 4-phase CPU port.
//
// state  | meaning
// C_IDLE | waiting for cpu_req; issues the RAM access on the first non-slot cycle
// C_DATA | RAM data ready; cpu_ack high for this one cycle
// C_WAIT | access done; waiting for cpu_req to drop
module tile_vram_fetch
    import tile_vram_pkg::*;
#(
    parameter int         COLS_LOG2   = DEF_COLS_LOG2,
    parameter int         ROWS_LOG2   = DEF_ROWS_LOG2,
    parameter int         ADDR_W      = COLS_LOG2 + ROWS_LOG2,
    parameter int         DATA_W      = 8,
    parameter logic [2:0] FETCH_PHASE = DEF_FETCH_PHASE
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              pix_ce,
    input  logic [8:0]        hpos,
    input  logic [7:0]        vpos,
    input  logic              disp_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] tile_code
);

    cpu_state_t        state, state_nxt;
    logic              disp_slot;
    logic              disp_pend;
    logic [ADDR_W-1:0] disp_addr;
    logic              cpu_issue;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_q;
    logic              lat_we;
    logic [DATA_W-1:0] lat_din;
    logic [DATA_W-1:0] cpu_dout_q;
    logic [DATA_W-1:0] data_now;
    logic              unused_bits;

    // H256 and the fine vertical lines do not take part in the tile address.
    assign unused_bits = ^{hpos[8], vpos[2:0]};

    assign disp_slot = pix_ce && (hpos[2:0] == FETCH_PHASE) && disp_en;
    assign disp_addr = {vpos[7:3], next_col(hpos[7:3])};

    always_comb begin
        state_nxt = state;
        cpu_issue = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_din   = cpu_din;
        case (state)
            C_IDLE: begin
                if (cpu_req && !disp_slot) begin
                    cpu_issue = 1'b1;
                    ram_we    = cpu_we;
                    ram_addr  = cpu_addr;
                    state_nxt = C_DATA;
                end
            end
            C_DATA: state_nxt = C_WAIT;
            C_WAIT: begin
                if (!cpu_req) begin
                    state_nxt = C_IDLE;
                end
            end
            default: state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state      <= C_IDLE;
            disp_pend  <= 1'b0;
            tile_code  <= '0;
            lat_we     <= 1'b0;
            lat_din    <= '0;
            cpu_dout_q <= '0;
        end else begin
            state     <= state_nxt;
            disp_pend <= disp_slot;
            if (disp_pend) begin
                tile_code <= ram_q;
            end
            if (cpu_issue) begin
                lat_we  <= cpu_we;
                lat_din <= cpu_din;
            end
            if (state == C_DATA) begin
                cpu_dout_q <= data_now;
            end
        end
    end

    // Writes echo the data sampled at issue; reads return the RAM word.
    assign data_now = lat_we ? lat_din : ram_q;
    assign cpu_ack  = (state == C_DATA);
    assign cpu_dout = (state == C_DATA) ? data_now : cpu_dout_q;

    vram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_vram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .q    (ram_q)
    );

endmodule
